// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, default widths and saturating-add helper for mac_acc
package mac_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
  localparam int DW_D = 8;
  localparam int AW_D = 32;
  localparam int QW = 2 * DW_D + 1;
  function automatic logic [AW_D:0] sat_add(input logic [AW_D-1:0] acc, input logic [QW-1:0] q);
    logic [AW_D:0] s;
    s = {acc[AW_D-1], acc} + {{(AW_D + 1 - QW){q[QW-1]}}, q};
    return (s[AW_D] != s[AW_D-1]) ? {1'b1, s[AW_D], {(AW_D - 1){~s[AW_D]}}} : {1'b0, s[AW_D-1:0]};
  endfunction
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: sign-extend a product, add it to the accumulator and clamp to AW bits
module mac_sat_add #(
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic [AW-1:0]   acc,
  input  logic [2*DW:0]   q,
  output logic [AW-1:0]   sum,
  output logic            ovf
);
  localparam int QW = 2 * DW + 1;
  logic [AW:0] s;
  always_comb begin
    s = {acc[AW-1], acc} + {{(AW + 1 - QW){q[QW-1]}}, q};
    // the two top bits of the AW+1-bit sum disagree exactly when it leaves AW-bit range
    ovf = s[AW] != s[AW-1];
    sum = ovf ? {s[AW], {(AW - 1){~s[AW]}}} : s[AW-1:0];
  end
endmodule

// File: rtl/mac_acc.sv
// mac_acc: sums a programmed number of signed products into a saturating accumulator
module mac_acc
  import mac_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW:0] in_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_sat
);
  state_e        state;
  logic [LW-1:0] cnt;
  logic [AW-1:0] acc, sum;
  logic          sat, ovf;
  mac_sat_add #(.DW(DW), .AW(AW)) u_add (.acc(acc), .q(in_q), .sum(sum), .ovf(ovf));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          sat <= 1'b0;
          cnt <= len;
          state <= (len == '0) ? DONE : ACC;
        end
        ACC: if (in_valid) begin
          acc <= sum;
          sat <= sat | ovf;
          cnt <= cnt - LW'(1);
          if (cnt == LW'(1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  assign out_acc = acc;
  assign out_sat = sat;
endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: randomized self-checking bench for mac_acc against a plain-arithmetic model
module tb_mac_acc;
  localparam int DW = 8, AW = 18, LW = 8;
  localparam int MAXV = 131071, MINV = -131072;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] len = '0;
  logic [2*DW:0] in_q = '0;
  logic in_ready, out_valid, out_sat;
  logic [AW-1:0] out_acc;
  int n_chk = 0, n_fail = 0;
  int prod[256];

  mac_acc #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic run_job(input int n, input int mode, output int cyc, output int acc_m,
                         output bit sat_m, output int acc_cnt, output bit rdy_seen);
    int idx = 0;
    int s;
    bit v;
    acc_m = 0; sat_m = 0; cyc = 0; acc_cnt = 0; rdy_seen = 0;
    start = 1; len = n[LW-1:0];
    @(posedge clk); #1;
    start = 0; cyc = 1;
    while (!out_valid && cyc < 600) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      rdy_seen |= in_ready;
      in_valid = v;
      in_q = v ? 17'(prod[idx]) : 17'($urandom);
      if (v && in_ready && idx < n) begin
        s = acc_m + prod[idx];
        if (s > MAXV) begin s = MAXV; sat_m = 1; end
        if (s < MINV) begin s = MINV; sat_m = 1; end
        acc_m = s; idx++; acc_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
  endtask

  task automatic release_result();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if ({in_ready, out_valid, out_sat} !== 3'b000 || out_acc !== '0) begin
      n_fail++; $display("FAIL reset: rdy=%b vld=%b sat=%b acc=%0d, required 0 0 0 0", in_ready, out_valid, out_sat, out_acc);
    end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc, am, ac; bit sm, rs;
    prod[0] = 10; prod[1] = -3; prod[2] = 127; prod[3] = -128;
    run_job(4, 0, cyc, am, sm, ac, rs);
    n_chk++; if (cyc != 5 || !out_valid) begin n_fail++; $display("FAIL basic_latency: cycles=%0d vld=%b, required 5 1", cyc, out_valid); end
    n_chk++; if (out_acc !== 18'(6) || am != 6) begin n_fail++; $display("FAIL basic_acc: got %0d, required 6", $signed(out_acc)); end
    n_chk++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b, required 0", out_sat); end
    release_result();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: vld=%b, required 0", out_valid); end
  endtask

  task automatic test_saturation();
    int cyc, am, ac; bit sm, rs;
    for (int k = 0; k < 3; k++) prod[k] = 65025;
    run_job(3, 0, cyc, am, sm, ac, rs);
    n_chk++; if (out_acc !== 18'(131071) || out_sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_pos: acc=%0d sat=%b, required 131071 1", $signed(out_acc), out_sat);
    end
    release_result();
    for (int k = 0; k < 3; k++) prod[k] = -65280;
    run_job(3, 0, cyc, am, sm, ac, rs);
    n_chk++; if (out_acc !== 18'(-131072) || out_sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_neg: acc=%0d sat=%b, required -131072 1", $signed(out_acc), out_sat);
    end
    release_result();
    prod[0] = 65025; prod[1] = 65025; prod[2] = 65025; prod[3] = -65280;
    run_job(4, 0, cyc, am, sm, ac, rs);
    n_chk++; if (out_acc !== 18'(am) || out_sat !== sm) begin
      n_fail++; $display("FAIL sat_sticky: acc=%0d sat=%b, required %0d %b", $signed(out_acc), out_sat, am, sm);
    end
    release_result();
  endtask

  task automatic test_zero_len();
    int cyc, am, ac; bit sm, rs;
    run_job(0, 0, cyc, am, sm, ac, rs);
    n_chk++; if (cyc != 1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_latency: cycles=%0d vld=%b, required 1 1", cyc, out_valid); end
    n_chk++; if (out_acc !== '0 || out_sat !== 1'b0) begin n_fail++; $display("FAIL zero_result: acc=%0d sat=%b, required 0 0", $signed(out_acc), out_sat); end
    n_chk++; if (in_ready !== 1'b0 || rs) begin n_fail++; $display("FAIL zero_ready: rdy=%b seen=%b, required 0 0", in_ready, rs); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int cyc, am, ac; bit sm, rs;
    logic [AW-1:0] held;
    bit moved = 0;
    for (int k = 0; k < 3; k++) prod[k] = $urandom_range(0, 130560) - 65280;
    run_job(3, 1, cyc, am, sm, ac, rs);
    n_chk++; if (ac != 3 || cyc != 6) begin n_fail++; $display("FAIL gap_accepts: accepts=%0d cycles=%0d, required 3 6", ac, cyc); end
    n_chk++; if (out_acc !== 18'(am) || out_sat !== sm) begin
      n_fail++; $display("FAIL gap_sum: acc=%0d sat=%b, required %0d %b", $signed(out_acc), out_sat, am, sm);
    end
    held = out_acc;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); len = 8'd5;
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_acc !== held) moved = 1;
    end
    start = 0;
    n_chk++; if (moved) begin n_fail++; $display("FAIL stall_hold: vld=%b rdy=%b acc=%0d, required 1 0 %0d", out_valid, in_ready, $signed(out_acc), $signed(held)); end
    release_result();
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL start_in_done: rdy=%b vld=%b, required 0 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, am, ac; bit sm, rs;
    start = 1; len = 8'd4;
    @(posedge clk); #1;
    start = 0; in_valid = 1;
    in_q = 17'(65025); @(posedge clk); #1;
    in_q = 17'(65025); @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0; #1;
    n_chk++; if ({in_ready, out_valid, out_sat} !== 3'b000 || out_acc !== '0) begin
      n_fail++; $display("FAIL reset_mid: rdy=%b vld=%b sat=%b acc=%0d, required 0 0 0 0", in_ready, out_valid, out_sat, out_acc);
    end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle: rdy=%b vld=%b, required 0 0", in_ready, out_valid); end
    prod[0] = -7;
    run_job(1, 0, cyc, am, sm, ac, rs);
    n_chk++; if (out_acc !== 18'(-7) || out_sat !== 1'b0 || cyc != 2) begin
      n_fail++; $display("FAIL reset_fresh: acc=%0d sat=%b cycles=%0d, required -7 0 2", $signed(out_acc), out_sat, cyc);
    end
    release_result();
  endtask

  task automatic test_random();
    int cyc, am, ac, n; bit sm, rs;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) prod[k] = $urandom_range(0, 130560) - 65280;
      run_job(n, 2, cyc, am, sm, ac, rs);
      n_chk++; if (!out_valid || ac != n || out_acc !== 18'(am) || out_sat !== sm) begin
        n_fail++; $display("FAIL random_%0d: vld=%b accepts=%0d acc=%0d sat=%b, required 1 %0d %0d %b", j, out_valid, ac, $signed(out_acc), out_sat, n, am, sm);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
